prio_read_scheduler: RTL and testbench

//  Read-side scheduler for a dual-queue (high/low) priority FIFO.
//  - Each cycle, selects which queue to pop and registers the selected word into a single output stage.
//  - The output stage uses a valid/ready handshake.
//  - High priority wins, except for a bounded anti-starvation guard that periodically forces one low-priority grant.
//  - Sits between the queue storage (first-word fall-through read) and the downstream consumer.

---
 rtl/prio_read_scheduler_if.sv | 27 ++
 rtl/prio_read_scheduler.sv | 110 +++++++++++
 tb/tb_prio_read_scheduler.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/prio_read_scheduler_if.sv
// Queue-side and consumer-side signals of the priority read scheduler.
// master = scheduler, slave = queue storage plus downstream consumer.
interface prio_read_scheduler_if #(
    parameter int unsigned WIDTH = 8
);
    logic             hi_empty;
    logic [WIDTH-1:0] hi_rdata;
    logic             hi_pop;
    logic             lo_empty;
    logic [WIDTH-1:0] lo_rdata;
    logic             lo_pop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_is_hi;
    logic             lo_forced;

    modport master (
        input  hi_empty, hi_rdata, lo_empty, lo_rdata, out_ready,
        output hi_pop, lo_pop, out_valid, out_data, out_is_hi, lo_forced
    );

    modport slave (
        output hi_empty, hi_rdata, lo_empty, lo_rdata, out_ready,
        input  hi_pop, lo_pop, out_valid, out_data, out_is_hi, lo_forced
    );
endinterface

// File: rtl/prio_read_scheduler.sv
// Read scheduler for a high/low priority FIFO pair with a registered valid/ready output stage.
// Define PRIO_SCHED_STARVE_GUARD_EN to enable the anti-starvation guard (forced low grants).
module prio_read_scheduler #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    prio_read_scheduler_if.master    bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("STARVE_LIMIT must be within 1..255");
    end

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             is_hi_q, is_hi_d;
    logic             force_lo;
    logic             pick_hi, pick_lo;
    logic             load_ok, grant;

`ifdef PRIO_SCHED_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             forced_q, forced_d;

    assign force_lo = (cnt_q == CNT_MAX) & ~bus.lo_empty;
`else
    assign force_lo = 1'b0;
`endif

    always_comb begin
        load_ok = (state_q == S_EMPTY) | bus.out_ready;
        pick_hi = ~bus.hi_empty & ~force_lo;
        pick_lo = ~pick_hi & ~bus.lo_empty;
        // rst_n gating keeps both pops low for the whole reset interval
        grant   = load_ok & en & rst_n;

        bus.hi_pop = grant & pick_hi;
        bus.lo_pop = grant & pick_lo;

        state_d = state_q;
        data_d  = data_q;
        is_hi_d = is_hi_q;

        if (bus.hi_pop | bus.lo_pop) begin
            state_d = S_FULL;
            data_d  = pick_hi ? bus.hi_rdata : bus.lo_rdata;
            is_hi_d = pick_hi;
        end else if ((state_q == S_FULL) && bus.out_ready) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            is_hi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            is_hi_q <= is_hi_d;
        end
    end

`ifdef PRIO_SCHED_STARVE_GUARD_EN
    always_comb begin
        cnt_d    = cnt_q;
        forced_d = bus.lo_pop & force_lo;
        if (bus.hi_pop) begin
            if (bus.lo_empty) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (bus.lo_pop) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            forced_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            forced_q <= forced_d;
        end
    end

    assign bus.lo_forced = forced_q;
`else
    assign bus.lo_forced = 1'b0;
`endif

    assign bus.out_valid = (state_q == S_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_is_hi = is_hi_q;

endmodule

// File: tb/tb_prio_read_scheduler.sv
// Directed bench for prio_read_scheduler; FWFT queues are modelled with SV queues.
// Expected guard behaviour follows PRIO_SCHED_STARVE_GUARD_EN as compiled.
module tb_prio_read_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    always #5 clk = ~clk;

    prio_read_scheduler_if #(.WIDTH(8)) bus ();

    prio_read_scheduler #(
        .WIDTH        (8),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    logic [7:0] hi_q[$];
    logic [7:0] lo_q[$];
    int errs   = 0;
    int checks = 0;

    logic [7:0] exp4_d[9];
    logic       exp4_h[9];
    logic       exp4_f[9];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic heads();
        bus.hi_empty = (hi_q.size() == 0);
        bus.hi_rdata = (hi_q.size() == 0) ? 8'h00 : hi_q[0];
        bus.lo_empty = (lo_q.size() == 0);
        bus.lo_rdata = (lo_q.size() == 0) ? 8'h00 : lo_q[0];
    endtask

    // One clock: sample pops before the edge, apply them to the queue model after it.
    task automatic cycle();
        logic hp, lp;
        @(negedge clk);
        hp = bus.hi_pop;
        lp = bus.lo_pop;
        chk("one_pop", {31'd0, hp & lp}, 32'd0);
        @(posedge clk);
        #1;
        if (hp && hi_q.size() > 0) void'(hi_q.pop_front());
        if (lp && lo_q.size() > 0) void'(lo_q.pop_front());
        heads();
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic h);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_data"},  {24'd0, bus.out_data},  {24'd0, d});
        chk({tag, "_is_hi"}, {31'd0, bus.out_is_hi}, {31'd0, h});
    endtask

    initial begin
`ifdef PRIO_SCHED_STARVE_GUARD_EN
        exp4_d = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h55, 8'h84, 8'h85, 8'h86, 8'h87};
        exp4_h = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp4_f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp4_d = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h55};
        exp4_h = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp4_f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

        // 1: reset held with a non-empty high queue
        rst_n = 1'b0;
        en = 1'b1;
        bus.out_ready = 1'b1;
        hi_q.push_back(8'hAA);
        heads();
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("t1_rst_hi_pop", {31'd0, bus.hi_pop}, 32'd0);
            chk("t1_rst_valid", {31'd0, bus.out_valid}, 32'd0);
            cycle();
        end
        chk("t1_rst_data", {24'd0, bus.out_data}, 32'd0);
        chk("t1_rst_forced", {31'd0, bus.lo_forced}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("t1_rel_hi_pop", {31'd0, bus.hi_pop}, 32'd1);
        cycle();
        expect_out("t1", 8'hAA, 1'b1);
        cycle();
        chk("t1_drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // 2: both queues loaded, back-to-back
        hi_q.push_back(8'h10);
        hi_q.push_back(8'h11);
        lo_q.push_back(8'h20);
        heads();
        #1;
        cycle();
        expect_out("t2_w0", 8'h10, 1'b1);
        cycle();
        expect_out("t2_w1", 8'h11, 1'b1);
        cycle();
        expect_out("t2_w2", 8'h20, 1'b0);
        cycle();
        chk("t2_drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // 3: backpressure holds the output word
        bus.out_ready = 1'b0;
        hi_q.push_back(8'h30);
        hi_q.push_back(8'h31);
        heads();
        #1;
        cycle();
        expect_out("t3_load", 8'h30, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_pop", {31'd0, bus.hi_pop}, 32'd0);
            cycle();
            expect_out("t3_stall", 8'h30, 1'b1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t3_resume_pop", {31'd0, bus.hi_pop}, 32'd1);
        cycle();
        expect_out("t3_next", 8'h31, 1'b1);
        cycle();
        chk("t3_drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // 4: eight high words against one pending low word
        for (int i = 0; i < 8; i++) hi_q.push_back(8'h80 + 8'(i));
        lo_q.push_back(8'h55);
        heads();
        #1;
        for (int i = 0; i < 9; i++) begin
            cycle();
            expect_out("t4", exp4_d[i], exp4_h[i]);
            chk("t4_forced", {31'd0, bus.lo_forced}, {31'd0, exp4_f[i]});
        end
        cycle();
        chk("t4_drain_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t4_drain_forced", {31'd0, bus.lo_forced}, 32'd0);

        // 5: enable gating
        en = 1'b0;
        hi_q.push_back(8'hA0);
        hi_q.push_back(8'hA1);
        heads();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("t5_dis_pop", {31'd0, bus.hi_pop}, 32'd0);
            cycle();
            chk("t5_dis_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        en = 1'b1;
        #1;
        chk("t5_en_pop", {31'd0, bus.hi_pop}, 32'd1);
        cycle();
        expect_out("t5_load", 8'hA0, 1'b1);
        en = 1'b0;
        bus.out_ready = 1'b0;
        cycle();
        expect_out("t5_hold", 8'hA0, 1'b1);
        bus.out_ready = 1'b1;
        #1;
        chk("t5_drain_pop", {31'd0, bus.hi_pop}, 32'd0);
        cycle();
        chk("t5_drained", {31'd0, bus.out_valid}, 32'd0);
        en = 1'b1;
        cycle();
        expect_out("t5_next", 8'hA1, 1'b1);
        cycle();
        chk("t5_empty", {31'd0, bus.out_valid}, 32'd0);

        // 6: reset while a word is held under backpressure
        bus.out_ready = 1'b0;
        hi_q.push_back(8'hC0);
        hi_q.push_back(8'hC1);
        hi_q.push_back(8'hC2);
        heads();
        #1;
        cycle();
        expect_out("t6_load", 8'hC0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_rst_data", {24'd0, bus.out_data}, 32'd0);
        chk("t6_rst_pop", {31'd0, bus.hi_pop}, 32'd0);
        cycle();
        chk("t6_rst_hold_valid", {31'd0, bus.out_valid}, 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("t6_rel_pop", {31'd0, bus.hi_pop}, 32'd1);
        cycle();
        expect_out("t6_w1", 8'hC1, 1'b1);
        cycle();
        expect_out("t6_w2", 8'hC2, 1'b1);
        cycle();
        chk("t6_empty", {31'd0, bus.out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
